md5_serial_sub: RTL and testbench
=================================

Name: md5_serial_sub

Overview:
- Digit-serial modular subtractor: computes diff = (a - b) mod 2^WIDTH, LSB-first, DIGIT bits per cycle, using a borrow chain.
- Inverse of the ripple full-adder path used for MD5 modular addition.
- Unwinds MD5 step additions (state recovery / early-reject of final round steps).
- Sits beside the MD5 round datapath; start/done handshake to the round controller.

Parameters:
WIDTH, 32, operand and result width in bits.
DIGIT, 1, bits processed per cycle; must divide WIDTH (legal: 1, 2, 4, 8, 16, 32).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
start  input  1  request; sampled on a rising clk edge when the block is ready.
a  input  WIDTH  minuend; captured on the accepted-start edge only.
b  input  WIDTH  subtrahend; captured on the accepted-start edge only.
ready  output  1  high in IDLE and DONE; a start is accepted only while ready=1.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse; result valid.
diff  output  WIDTH  (a - b) mod 2^WIDTH; held until the next done.
borrow_out  output  1  final borrow (1 iff a < b unsigned); held with diff.

Behaviour:
- Reset (rst_n=0 at a clk edge) takes effect on that edge:
  - state=IDLE; ready=1, busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow and counter cleared.
  - Reset mid-RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b; borrow=0; cnt=0; go to RUN.
  - RUN: each edge consumes the low DIGIT bits of each operand register.
    - {bout, d} = a_dig - b_dig - borrow, computed as DIGIT chained 1-bit full-subtractor cells: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
    - d shifts into the result register from the top (LSB-first assembly).
    - Operand registers shift right by DIGIT; borrow <= bout; cnt++.
    - On the edge where cnt = WIDTH/DIGIT-1: load diff and borrow_out, pulse done=1, go to DONE.
  - DONE (one cycle): done=1, ready=1. start=1 here is accepted exactly as in IDLE (go to RUN); otherwise go to IDLE.
- Latency: start accepted at edge E -> done=1 in the cycle after edge E + WIDTH/DIGIT (32 cycles for defaults).
  - Throughput: one operation per WIDTH/DIGIT+1 cycles with back-to-back starts.
- start while busy=1 is ignored: operands are not recaptured and the count is not disturbed.
- a and b may change freely after the capture edge.
- diff and borrow_out change only on the done edge (and on reset); they stay stable in RUN for the previous result.
- Arithmetic is unsigned mod 2^WIDTH; no overflow flag beyond borrow_out.
- The counter is sized for clog2(WIDTH/DIGIT) bits. With DIGIT=WIDTH, RUN lasts exactly one cycle.

Test Plan:
- Default params: a=0x00000005, b=0x00000003, start for 1 cycle -> busy high for 32 cycles, then done=1 for 1 cycle; diff=0x00000002, borrow_out=0.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow_out=1; a=b=0x67452301 -> diff=0x00000000, borrow_out=0.
- Hold start=1 continuously with new operands each cycle -> each accepted op latches operands only at its start edge; done every 33 cycles; results match the operands captured at each start edge.
- rst_n=0 for 1 cycle at RUN cycle 10 of a=0xEFCDAB89, b=0x98BADCFE -> no done; outputs zero, ready=1. Restart the same op -> diff=0x5712CE8B, borrow_out=0.
- DIGIT=4: a=0x10000000, b=0x0FFFFFFF -> done 8 cycles after the start edge; diff=0x00000001, borrow_out=0.
- Random regression, 10k ops each for DIGIT in {1, 8, 32} -> diff == (a-b) mod 2^32 and borrow_out == (a<b) for every op.

Source files
------------

// File: rtl/md5_serial_sub.sv
// md5_serial_sub: digit-serial (a - b) mod 2^WIDTH, LSB-first borrow chain with start/done handshake
module md5_serial_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DN = 2'd2;
  logic [1:0]             state;
  logic [WIDTH-1:0]       ra, rb, rd;
  logic [DIGIT-1:0]       dig;
  logic [CW-1:0]          cnt;
  logic [WIDTH+DIGIT-1:0] cat;
  logic                   brw, bin, bout;
  assign ready = state != RUN;
  assign busy  = state == RUN;
  assign done  = state == DN;
  // DIGIT chained full-subtractor cells on the low operand bits
  always_comb begin
    bin = brw;
    dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dig[i] = ra[i] ^ rb[i] ^ bin;
      bin    = (~ra[i] & rb[i]) | (~(ra[i] ^ rb[i]) & bin);
    end
    bout = bin;
  end
  // new digit enters at the top so the result ends up LSB-aligned after N steps
  assign cat = {dig, rd};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ra         <= '0;
      rb         <= '0;
      rd         <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (busy) begin
      ra  <= ra >> DIGIT;
      rb  <= rb >> DIGIT;
      rd  <= cat[WIDTH+DIGIT-1:DIGIT];
      brw <= bout;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) begin
        diff       <= cat[WIDTH+DIGIT-1:DIGIT];
        borrow_out <= bout;
        state      <= DN;
      end
    end else if (start) begin
      ra    <= a;
      rb    <= b;
      brw   <= 1'b0;
      cnt   <= '0;
      state <= RUN;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_md5_serial_sub.sv
// tb_md5_serial_sub: scoreboard bench over DIGIT in {1,4,8,32}; model is plain (a-b, a<b)
module tb_md5_serial_sub;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask
  typedef struct {
    logic [31:0] d;
    logic        br;
    int          s;
  } exp_t;
  for (genvar k = 0; k < 4; k++) begin : g
    localparam int D = (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 8 : 32;
    localparam int N = 32 / D;
    logic        rst_n = 1'b0, start = 1'b0, ready, busy, done, bo;
    logic [31:0] a = '0, b = '0, diff, last = '0;
    logic        lastb = 1'b0;
    bit          armed = 0, fin = 0;
    int          ndone = 0;
    exp_t        q[$];
    exp_t        e;
    md5_serial_sub #(.WIDTH(32), .DIGIT(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ready(ready),
      .busy(busy), .done(done), .diff(diff), .borrow_out(bo)
    );
    // monitor: pops expectations on done, otherwise checks outputs are held
    always @(negedge clk) if (armed) begin
      chk($sformatf("d%0d ready/busy", D), ready, !busy);
      if (done) begin
        ndone++;
        if (q.size() == 0) chk($sformatf("d%0d unexpected done", D), 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("d%0d diff", D), diff, e.d);
          chk($sformatf("d%0d borrow", D), bo, e.br);
          chk($sformatf("d%0d latency", D), cyc - e.s, N);
          last  = e.d;
          lastb = e.br;
        end
      end else begin
        chk($sformatf("d%0d diff hold", D), diff, last);
        chk($sformatf("d%0d borrow hold", D), bo, lastb);
      end
      if (!rst_n) begin
        last  = '0;
        lastb = 1'b0;
      end
    end
    task automatic tick();
      @(posedge clk);
      #1;
    endtask
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
      int t = 0;
      while (!ready && t < 200) begin
        tick();
        t++;
      end
      chk($sformatf("d%0d ready wait", D), ready, 1);
      start = 1'b1;
      a = x;
      b = y;
      q.push_back('{x - y, x < y, cyc + 1});
      tick();
      start = 1'b0;
      a = $urandom;
      b = $urandom;
    endtask
    task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 2000) begin
        tick();
        t++;
      end
      chk($sformatf("d%0d drained", D), q.size(), 0);
    endtask
    initial begin
      int n0, acc, t;
      logic [31:0] x, y;
      repeat (2) tick();
      rst_n = 1'b1;
      armed = 1;
      @(negedge clk);
      chk($sformatf("d%0d reset state", D), {ready, busy, done, bo, diff}, {4'b1000, 32'h0});
      tick();
      issue(32'h5, 32'h3);                  drain();
      issue(32'h0, 32'h1);                  drain();
      issue(32'h67452301, 32'h67452301);    drain();
      issue(32'h10000000, 32'h0FFFFFFF);    drain();
      issue(32'hFFFFFFFF, 32'h0);           drain();
      issue(32'hEFCDAB89, 32'h98BADCFE);
      repeat (9) tick();
      rst_n = 1'b0;
      q.delete();
      tick();
      rst_n = 1'b1;
      n0 = ndone;
      repeat (N + 5) tick();
      chk($sformatf("d%0d no done after reset", D), ndone, n0);
      chk($sformatf("d%0d post-reset outputs", D), {ready, busy, bo, diff}, {3'b100, 32'h0});
      issue(32'hEFCDAB89, 32'h98BADCFE);    drain();
      // start held mostly high with fresh operands every cycle
      acc = 0;
      t = 0;
      while (acc < 1000 && t < 60000) begin
        x = $urandom;
        case ($urandom % 8)
          0:       y = x;
          1:       y = 32'hFFFFFFFF;
          2:       y = x + 32'h1;
          default: y = $urandom;
        endcase
        a = x;
        b = y;
        start = ($urandom % 8) != 0;
        if (start && ready) begin
          q.push_back('{x - y, x < y, cyc + 1});
          acc++;
        end
        tick();
        t++;
      end
      start = 1'b0;
      chk($sformatf("d%0d random ops issued", D), acc, 1000);
      drain();
      fin = 1;
    end
  end
  initial begin
    int t = 0;
    while (!(g[0].fin && g[1].fin && g[2].fin && g[3].fin) && t < 90000) begin
      @(posedge clk);
      t++;
    end
    chk("all blocks finished", {g[0].fin, g[1].fin, g[2].fin, g[3].fin}, 4'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
